// File: rtl/status_master_if.sv
// Single-word status BRAM port shared by the status initiator and the
// BRAM/PL side. Word address, 64-bit write word, 32-bit read word.
interface status_master_if;
  logic [1:0]  bram_addr;
  logic [63:0] bram_din;
  logic        bram_wen;
  logic [31:0] bram_dout;

  modport master (
    output bram_addr,
    output bram_din,
    output bram_wen,
    input  bram_dout
  );

  modport slave (
    input  bram_addr,
    input  bram_din,
    input  bram_wen,
    output bram_dout
  );
endinterface

// File: rtl/status_master.sv
// Initiator end of the PS/PL status-word handshake. On start it waits for
// any stale completion bit to clear, pulses the command flag in the upper
// half of word 0 for HOLD_CYCLES, clears it, then polls bit 0 of the lower
// half until the PL reports completion or the ARM+POLL budget runs out.
module status_master #(
  parameter int HOLD_CYCLES    = 2,
  parameter int READ_LAT       = 1,
  parameter int POLL_GAP       = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_W-1:0]     latency,
  status_master_if.master      bram
);

  // One shared down-time counter serves the hold, read-wait and gap phases.
  localparam int WAIT_MAX_A = (HOLD_CYCLES > READ_LAT) ? HOLD_CYCLES : READ_LAT;
  localparam int WAIT_MAX   = (WAIT_MAX_A > POLL_GAP) ? WAIT_MAX_A : POLL_GAP;
  localparam int WAIT_W     = $clog2(WAIT_MAX + 1);
  localparam int TO_W       = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [WAIT_W-1:0] HOLD_LAST = WAIT_W'(HOLD_CYCLES - 1);
  localparam logic [WAIT_W-1:0] RL_LAST   = WAIT_W'(READ_LAT);
  localparam logic [WAIT_W-1:0] GAP_LAST  = WAIT_W'((POLL_GAP == 0) ? 0 : POLL_GAP - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_SET,
    S_CLR,
    S_POLL
  } state_t;

  state_t            state_reg, state_next;
  logic              gap_reg, gap_next;         // 1 = idling between reads
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic [TO_W-1:0]   to_reg, to_next;
  logic [CNT_W-1:0]  lat_reg, lat_next;         // running flag-to-done count
  logic [CNT_W-1:0]  lat_sat;
  logic [CNT_W-1:0]  latency_reg, latency_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              timeout_reg, timeout_next;
  logic              wen_c;
  logic [63:0]       din_c;
  logic              unused_dout_bits;

  // Only bit 0 of the read word carries the PL completion flag.
  assign unused_dout_bits = ^bram.bram_dout[31:1];

  // Latency count stops at all-ones instead of wrapping.
  assign lat_sat = (lat_reg == {CNT_W{1'b1}}) ? lat_reg : lat_reg + CNT_W'(1);

  // Next-state, counters and BRAM drive for the handshake sequence.
  always_comb begin
    state_next   = state_reg;
    gap_next     = gap_reg;
    wait_next    = wait_reg;
    to_next      = to_reg;
    lat_next     = lat_reg;
    latency_next = latency_reg;
    done_next    = 1'b0;
    timeout_next = 1'b0;
    wen_c        = 1'b0;
    din_c        = '0;

    case (state_reg)
      S_IDLE: begin
        // busy_reg also covers the done/timeout pulse cycle, so a start
        // arriving on that cycle is dropped.
        if (start && !busy_reg) begin
          state_next = S_ARM;
          gap_next   = 1'b0;
          wait_next  = '0;
          to_next    = '0;
        end
      end

      S_ARM, S_POLL: begin
        to_next = to_reg + TO_W'(1);
        if (state_reg == S_POLL) begin
          lat_next = lat_sat;
        end
        if (to_reg == TO_LAST) begin
          // Budget exhausted; checked first so it beats a same-cycle sample.
          timeout_next = 1'b1;
          state_next   = S_IDLE;
        end else if (!gap_reg) begin
          if (wait_reg == RL_LAST) begin
            if (state_reg == S_ARM && !bram.bram_dout[0]) begin
              state_next = S_SET;
              wait_next  = '0;
              lat_next   = '0;
            end else if (state_reg == S_POLL && bram.bram_dout[0]) begin
              done_next    = 1'b1;
              latency_next = lat_reg;
              state_next   = S_IDLE;
            end else begin
              wait_next = '0;
              gap_next  = (POLL_GAP != 0);
            end
          end else begin
            wait_next = wait_reg + WAIT_W'(1);
          end
        end else begin
          if (wait_reg == GAP_LAST) begin
            gap_next  = 1'b0;
            wait_next = '0;
          end else begin
            wait_next = wait_reg + WAIT_W'(1);
          end
        end
      end

      S_SET: begin
        wen_c         = 1'b1;
        din_c[63:32]  = 32'h1;
        lat_next      = lat_sat;
        if (wait_reg == HOLD_LAST) begin
          state_next = S_CLR;
          wait_next  = '0;
        end else begin
          wait_next = wait_reg + WAIT_W'(1);
        end
      end

      S_CLR: begin
        // din stays zero: this write drops the flag the receiver edge-detects.
        wen_c      = 1'b1;
        lat_next   = lat_sat;
        state_next = S_POLL;
        gap_next   = 1'b0;
        wait_next  = '0;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    busy_next = (state_next != S_IDLE) || done_next || timeout_next;
  end

  // State and counter registers; reset abandons any command in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      gap_reg     <= 1'b0;
      wait_reg    <= '0;
      to_reg      <= '0;
      lat_reg     <= '0;
      latency_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      gap_reg     <= gap_next;
      wait_reg    <= wait_next;
      to_reg      <= to_next;
      lat_reg     <= lat_next;
      latency_reg <= latency_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      timeout_reg <= timeout_next;
    end
  end

  assign busy           = busy_reg;
  assign done           = done_reg;
  assign timeout        = timeout_reg;
  assign latency        = latency_reg;
  assign bram.bram_addr = 2'b00;
  assign bram.bram_wen  = wen_c;
  assign bram.bram_din  = din_c;

endmodule

// File: tb/tb_status_master.sv
// Bench for status_master: a PL-side model drives the completion bit, and
// each command is checked against hand-derived vectors and a timing model.
module tb_status_master;
  localparam int H   = 2;
  localparam int RL  = 1;
  localparam int GAP = 4;
  localparam int TO  = 100;
  localparam int CW  = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] latency;

  status_master_if bus();

  status_master #(
    .HOLD_CYCLES(H), .READ_LAT(RL), .POLL_GAP(GAP),
    .TIMEOUT_CYCLES(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .timeout(timeout), .latency(latency), .bram(bus)
  );

  always #5 clk = ~clk;

  // Offsets are in cycles relative to the cycle start is driven high.
  typedef struct {
    int stale_len;   // PL bit0 reads 1 for cycles < start+stale_len
    int delay;       // PL bit0 rises this many cycles after the clearing write
    bit junk;        // extra starts while busy and on the pulse cycle
    bit exp_done;    // 1 = done pulse, 0 = timeout pulse
    int pulse_off;
    int latency;
    int set_off;     // first flag write, -1 when no write expected
  } vec_t;

  vec_t vecs[11];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Timing model: the master samples bit0 every READ_LAT+1+POLL_GAP cycles
  // starting READ_LAT cycles into each read phase; ARM and POLL cycles
  // together are capped at TIMEOUT_CYCLES.
  function automatic vec_t model(input int stale_len, input int delay);
    vec_t r;
    int   per, e, ts, used, f;
    bit   in_poll;
    per = RL + 1 + GAP;
    r.stale_len = stale_len; r.delay = delay; r.junk = 1'b0;
    r.set_off = -1; r.latency = 0; r.exp_done = 1'b0; r.pulse_off = -1;
    e = 1; ts = 1 + RL; used = 0; in_poll = 1'b0; f = 0;
    for (int it = 0; it < 10000; it++) begin
      if (used + (ts - e + 1) >= TO) begin
        r.exp_done  = 1'b0;
        r.pulse_off = e + (TO - used);
        return r;
      end
      if (!in_poll) begin
        if (ts >= stale_len) begin
          f = ts + 1; r.set_off = f;
          used += ts - e + 1;
          e = f + H + 1; ts = e + RL; in_poll = 1'b1;
        end else begin
          ts += per;
        end
      end else begin
        if (ts >= f + H + delay) begin
          r.exp_done = 1'b1; r.pulse_off = ts + 1; r.latency = ts - f;
          return r;
        end
        ts += per;
      end
    end
    return r;
  endfunction

  // Issue one command, play the PL side, and check the resulting trace.
  task automatic run_txn(input vec_t e, input string tag);
    int s, clr_seen, p, first_hi, n_hi, n_lo, lo_cyc, n_done, n_to, lat_at;
    int busy_s1, busy_p, busy_p1;
    bit inv_ok, post_ok;
    s = cyc; clr_seen = -1; p = -1; first_hi = -1; n_hi = 0; n_lo = 0;
    lo_cyc = -1; n_done = 0; n_to = 0; lat_at = -1;
    busy_s1 = -1; busy_p = -1; busy_p1 = -1; inv_ok = 1'b1; post_ok = 1'b1;
    for (int k = 0; k < 600; k++) begin
      if (bus.bram_addr != 2'b00 || bus.bram_din[31:0] != 32'd0 ||
          (!bus.bram_wen && bus.bram_din != 64'd0)) inv_ok = 1'b0;
      if (cyc == s + 1) busy_s1 = busy;
      if (bus.bram_wen) begin
        if (bus.bram_din[63:32] == 32'd1) begin
          if (first_hi < 0) first_hi = cyc;
          n_hi++;
        end else if (bus.bram_din[63:32] == 32'd0) begin
          n_lo++; lo_cyc = cyc;
          if (clr_seen < 0) clr_seen = cyc;
        end else begin
          inv_ok = 1'b0;
        end
      end
      if (done) begin n_done++; lat_at = int'(latency); end
      if (timeout) n_to++;
      if (p < 0 && (done || timeout)) begin p = cyc; busy_p = busy; end
      if (p >= 0 && cyc == p + 1) busy_p1 = busy;
      if (p >= 0 && cyc > p && (busy || bus.bram_wen)) post_ok = 1'b0;
      bus.bram_dout = {31'd0, (cyc < s + e.stale_len) ||
                              (clr_seen >= 0 && cyc >= clr_seen + e.delay)};
      start = (cyc == s) || (e.junk && (cyc == s + 5 || cyc == s + e.pulse_off));
      if (p >= 0 && cyc >= p + 3) break;
      step();
    end
    start = 1'b0;
    check({tag, " done_pulses"}, n_done, e.exp_done ? 1 : 0);
    check({tag, " timeout_pulses"}, n_to, e.exp_done ? 0 : 1);
    check({tag, " pulse_cycle"}, (p < 0) ? -1 : p - s, e.pulse_off);
    if (e.exp_done) check({tag, " latency"}, lat_at, e.latency);
    check({tag, " flag_writes"}, n_hi, (e.set_off >= 0) ? H : 0);
    check({tag, " clear_writes"}, n_lo, (e.set_off >= 0) ? 1 : 0);
    if (e.set_off >= 0) begin
      check({tag, " set_cycle"}, first_hi - s, e.set_off);
      check({tag, " clr_cycle"}, lo_cyc - s, e.set_off + H);
    end
    check({tag, " busy_after_start"}, busy_s1, 1);
    check({tag, " busy_on_pulse"}, busy_p, 1);
    check({tag, " busy_after_pulse"}, busy_p1, 0);
    check({tag, " bus_invariants"}, inv_ok, 1);
    check({tag, " quiet_after_pulse"}, post_ok, 1);
    $display("txn %s: stale=%0d delay=%0d junk=%0d pulse@+%0d done=%0d timeout=%0d latency=%0d",
             tag, e.stale_len, e.delay, e.junk, (p < 0) ? -1 : p - s, n_done, n_to, lat_at);
  endtask

  initial begin
    int  s;
    bit  idle_wen, idle_busy, idle_pulse, idle_din;
    vec_t r;

    //            stale  delay  junk done pulse lat  set
    vecs[0]  = '{0,     20,    0,   1,   26,   22,  3};
    vecs[1]  = '{15,    20,    0,   1,   44,   22,  21};
    vecs[2]  = '{0,     0,     0,   1,   8,    4,   3};
    vecs[3]  = '{0,     3,     0,   1,   14,   10,  3};
    vecs[4]  = '{0,     92,    0,   1,   98,   94,  3};
    vecs[5]  = '{0,     98,    0,   0,   104,  0,   3};
    vecs[6]  = '{0,     100000,0,   0,   104,  0,   3};
    vecs[7]  = '{1000,  20,    0,   0,   101,  0,   -1};
    vecs[8]  = '{0,     20,    1,   1,   26,   22,  3};
    vecs[9]  = '{8,     20,    0,   1,   32,   22,  9};
    vecs[10] = '{9,     20,    0,   1,   38,   22,  15};

    rst = 1'b1; start = 1'b0; bus.bram_dout = 32'd0;
    repeat (3) step();
    rst = 1'b0;

    // Idle after reset: nothing may move.
    idle_wen = 0; idle_busy = 0; idle_pulse = 0; idle_din = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.bram_wen) idle_wen = 1;
      if (busy) idle_busy = 1;
      if (done || timeout) idle_pulse = 1;
      if (bus.bram_din != 64'd0) idle_din = 1;
      step();
    end
    check("idle wen", idle_wen, 0);
    check("idle busy", idle_busy, 0);
    check("idle pulses", idle_pulse, 0);
    check("idle din", idle_din, 0);
    check("reset latency", latency, 0);

    for (int i = 0; i < 11; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset while the flag is being written: no clearing write follows.
    s = cyc; bus.bram_dout = 32'd0; start = 1'b1;
    step(); start = 1'b0;
    step(); step();
    check("rst_seq set_active", bus.bram_wen, 1);
    rst = 1'b1;
    step();
    check("rst_seq wen", bus.bram_wen, 0);
    check("rst_seq din_zero", bus.bram_din == 64'd0, 1);
    check("rst_seq busy", busy, 0);
    check("rst_seq latency", latency, 0);
    check("rst_seq pulses", done || timeout, 0);
    $display("txn rst_seq: reset at +%0d during flag hold", cyc - s - 1);
    rst = 1'b0;
    step();
    run_txn(vecs[0], "post_rst");

    for (int i = 0; i < 30; i++) begin
      r = model($urandom_range(0, 30), $urandom_range(0, 110));
      r.junk = $urandom_range(0, 1) == 1;
      run_txn(r, $sformatf("rand%0d", i));
      repeat ($urandom_range(0, 3)) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
